// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer driving word-wide mem_data with sub-word RMW.
// Optional MAU_LDFWD_EN adds a last-write record that serves matching loads and sub-word stores.
module mem_access_unit #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic [31:0]   mem_addr,
  output logic          mem_read_control,
  output logic          write_data_control,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);
  typedef enum logic [2:0] {IDLE, LD_RD, LD_CAP, ST_WR, RMW_RD, RMW_CAP, RMW_WR, RESP} state_t;
  state_t state_q;
  logic [1:0] off_q, size_q;
  logic sgn_q, fwd_q, ready_q, valid_q, err_q, rd_q, wr_q;
  logic [31:0] wdata_q, rdata_q, addr_q, wd_q;
  logic err_d, hit_d;
  logic [31:0] rec_d;
  function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] off, input logic [1:0] sz,
                                      input logic sg);
    logic [31:0] s;
    s = w >> {off, 3'b000};
    return sz == 2'b00 ? {{24{sg & s[7]}}, s[7:0]} : sz == 2'b01 ? {{16{sg & s[15]}}, s[15:0]} : s;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d, input logic [1:0] off,
                                        input logic [1:0] sz);
    logic [31:0] m;
    m = (sz == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << {off, 3'b000};
    return (w & ~m) | ((d << {off, 3'b000}) & m);
  endfunction
  assign err_d = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`ifdef MAU_LDFWD_EN
  logic rec_v_q;
  logic [31:0] rec_a_q, rec_d_q;
  // The record mirrors every committed write strobe, so it always matches mem_data.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rec_v_q <= 1'b0;
      rec_a_q <= '0;
      rec_d_q <= '0;
    end else if (wr_q) begin
      rec_v_q <= 1'b1;
      rec_a_q <= addr_q;
      rec_d_q <= wd_q;
    end
  assign hit_d = rec_v_q && rec_a_q == 32'(req_addr[AW-1:2]);
  assign rec_d = rec_d_q;
`else
  assign hit_d = 1'b0;
  assign rec_d = '0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      fwd_q   <= 1'b0;
      sgn_q   <= 1'b0;
      off_q   <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          ready_q <= 1'b0;
          off_q   <= req_addr[1:0];
          size_q  <= req_size;
          sgn_q   <= req_signed;
          wdata_q <= req_wdata;
          addr_q  <= 32'(req_addr[AW-1:2]);
          rdata_q <= '0;
          fwd_q   <= hit_d;
          if (err_d) begin
            state_q <= RESP;
            valid_q <= 1'b1;
            err_q   <= 1'b1;
          end else if (!req_we) begin
            state_q <= hit_d ? LD_CAP : LD_RD;
            rd_q    <= !hit_d;
          end else if (req_size == 2'b10) begin
            state_q <= ST_WR;
            wr_q    <= 1'b1;
            wd_q    <= req_wdata;
          end else if (hit_d) begin
            state_q <= RMW_WR;
            wr_q    <= 1'b1;
            wd_q    <= merge(rec_d, req_wdata, req_addr[1:0], req_size);
          end else begin
            state_q <= RMW_RD;
            rd_q    <= 1'b1;
          end
        end
        LD_RD: begin
          rd_q    <= 1'b0;
          state_q <= LD_CAP;
        end
        LD_CAP: begin
          rdata_q <= fmt(fwd_q ? rec_d : mem_rdata, off_q, size_q, sgn_q);
          valid_q <= 1'b1;
          state_q <= RESP;
        end
        ST_WR, RMW_WR: begin
          wr_q    <= 1'b0;
          valid_q <= 1'b1;
          state_q <= RESP;
        end
        RMW_RD: begin
          rd_q    <= 1'b0;
          state_q <= RMW_CAP;
        end
        RMW_CAP: begin
          wd_q    <= merge(mem_rdata, wdata_q, off_q, size_q);
          wr_q    <= 1'b1;
          state_q <= RMW_WR;
        end
        RESP: begin
          valid_q <= 1'b0;
          err_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign req_ready          = ready_q;
  assign resp_valid         = valid_q;
  assign resp_rdata         = rdata_q;
  assign resp_err           = err_q;
  assign mem_addr           = addr_q;
  assign mem_read_control   = rd_q;
  assign write_data_control = wr_q;
  assign mem_wdata          = wd_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed table, reset-abort sequence and random traffic against a byte-array model.
module tb_mem_access_unit;
`ifdef MAU_LDFWD_EN
  localparam bit FWD = 1'b1;
  localparam int FL = 2, FS = 2;
`else
  localparam bit FWD = 1'b0;
  localparam int FL = 3, FS = 4;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0] req_size = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
  logic req_ready, resp_valid, resp_err, mem_read_control, write_data_control;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  always #5 clk = ~clk;
  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_read_control(mem_read_control), .write_data_control(write_data_control),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  logic [31:0] mem [16] = '{default: 32'h0};
  int nrd = 0, nwr = 0, nboth = 0;
  logic [31:0] wa = '0, wdat = '0;
  always @(posedge clk) begin
    if (mem_read_control) mem_rdata <= mem[mem_addr[3:0]];
    if (write_data_control) begin
      mem[mem_addr[3:0]] <= mem_wdata;
      nwr <= nwr + 1;
      wa <= mem_addr;
      wdat <= mem_wdata;
    end
    if (mem_read_control) nrd <= nrd + 1;
    if (mem_read_control && write_data_control) nboth <= nboth + 1;
  end
  int checks = 0, fails = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  // Reference memory as bytes plus the last-written word for the forwarding latency rule.
  logic [7:0] rb [64] = '{default: 8'h0};
  logic lv = 1'b0;
  int lw = 0;
  task automatic model(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wdt, output logic [31:0] erd, output logic eer,
                       output int elat, output logic [31:0] ewd);
    int n, w;
    logic hit;
    n = 1 << sz;
    w = int'(a) / 4;
    eer = sz == 2'd3 || (int'(a) % n) != 0;
    erd = '0;
    ewd = '0;
    hit = FWD && lv && lw == w;
    if (eer) elat = 1;
    else if (!we) begin
      for (int i = 0; i < n; i++) erd |= {24'h0, rb[int'(a) + i]} << (8 * i);
      if (sg && n < 4 && erd[8 * n - 1]) erd |= 32'hFFFF_FFFF << (8 * n);
      elat = hit ? 2 : 3;
    end else begin
      for (int i = 0; i < n; i++) rb[int'(a) + i] = wdt[8 * i +: 8];
      for (int i = 0; i < 4; i++) ewd |= {24'h0, rb[4 * w + i]} << (8 * i);
      elat = (n == 4 || hit) ? 2 : 4;
      lv = 1'b1;
      lw = w;
    end
  endtask
  task automatic run_req(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wdt, output int lat, output logic [31:0] rd,
                         output logic er, output int drd, output int dwr);
    int r0, w0, t;
    t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready_idle", 32'(req_ready), 1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wdt;
    r0 = nrd;
    w0 = nwr;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    drd = nrd - r0;
    dwr = nwr - w0;
    @(negedge clk);
    chk("resp_one_cycle", 32'(resp_valid), 0);
  endtask
  typedef struct {
    logic we; logic [1:0] sz; logic sg; logic [31:0] a, wd, erd; logic eer; int elat; logic [31:0] ewd;
  } vec_t;
  vec_t tbl[13];
  task automatic check_all(input string nm, input logic we, input logic [31:0] a, input int lat,
                           input logic [31:0] rd, input logic er, input int drd, input int dwr,
                           input logic [31:0] erd, input logic eer, input int elat, input logic [31:0] ewd);
    chk({nm, "_lat"}, lat, elat);
    chk({nm, "_rdata"}, rd, erd);
    chk({nm, "_err"}, 32'(er), 32'(eer));
    chk({nm, "_rd_pulses"}, drd, elat >= 3 ? 1 : 0);
    chk({nm, "_wr_pulses"}, dwr, (we && !eer) ? 1 : 0);
    if (we && !eer) begin
      chk({nm, "_wr_addr"}, wa, a >> 2);
      chk({nm, "_wr_data"}, wdat, ewd);
    end
  endtask
  initial begin
    int lat, drd, dwr, w0, elat;
    logic [31:0] rd, erd, ewd, a, wd;
    logic er, eer, we, sg;
    logic [1:0] sz;
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h8, 32'h0008_77F8, 32'h0, 1'b0, 2, 32'h0008_77F8};
    tbl[1]  = '{1'b0, 2'd0, 1'b1, 32'h8, 32'h0, 32'hFFFF_FFF8, 1'b0, FL, 32'h0};
    tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'h8, 32'h0, 32'h0000_00F8, 1'b0, FL, 32'h0};
    tbl[3]  = '{1'b0, 2'd1, 1'b1, 32'hA, 32'h0, 32'h0000_0008, 1'b0, FL, 32'h0};
    tbl[4]  = '{1'b0, 2'd1, 1'b0, 32'h8, 32'h0, 32'h0000_77F8, 1'b0, FL, 32'h0};
    tbl[5]  = '{1'b1, 2'd0, 1'b0, 32'h9, 32'h0000_00AB, 32'h0, 1'b0, FS, 32'h0008_ABF8};
    tbl[6]  = '{1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'h0008_ABF8, 1'b0, FL, 32'h0};
    tbl[7]  = '{1'b0, 2'd1, 1'b1, 32'h9, 32'h0, 32'h0, 1'b1, 1, 32'h0};
    tbl[8]  = '{1'b0, 2'd3, 1'b0, 32'h8, 32'h0, 32'h0, 1'b1, 1, 32'h0};
    tbl[9]  = '{1'b1, 2'd1, 1'b0, 32'h2, 32'h1234_8001, 32'h0, 1'b0, 4, 32'h8001_0000};
    tbl[10] = '{1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 32'hFFFF_8001, 1'b0, FL, 32'h0};
    tbl[11] = '{1'b0, 2'd0, 1'b1, 32'h3, 32'h0, 32'hFFFF_FF80, 1'b0, FL, 32'h0};
    tbl[12] = '{1'b1, 2'd2, 1'b0, 32'h6, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 32'h0};
    #12;
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_strobes", {30'h0, mem_read_control, write_data_control}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rdata_err", resp_rdata | 32'(resp_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    foreach (tbl[i]) begin
      model(tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, erd, eer, elat, ewd);
      run_req(tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, lat, rd, er, drd, dwr);
      check_all($sformatf("vec%0d", i), tbl[i].we, tbl[i].a, lat, rd, er, drd, dwr,
                tbl[i].erd, tbl[i].eer, tbl[i].elat, tbl[i].ewd);
    end
    // sb 0x55 at 0x8, reset lands in the capture/merge cycle
    w0 = nwr;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h8; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_wr_strobe", 32'(write_data_control), 0);
    chk("abort_rd_strobe", 32'(mem_read_control), 0);
    chk("abort_ready", 32'(req_ready), 1);
    chk("abort_mem_wdata", mem_wdata, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lv = 1'b0;
    chk("abort_no_write", nwr - w0, 0);
    @(negedge clk);
    run_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, lat, rd, er, drd, dwr);
    check_all("post_abort_lw", 1'b0, 32'h8, lat, rd, er, drd, dwr, 32'h0008_ABF8, 1'b0, 3, 32'h0);
    model(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, erd, eer, elat, ewd);
    run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, rd, er, drd, dwr);
    check_all("sw_10", 1'b1, 32'h10, lat, rd, er, drd, dwr, 32'h0, 1'b0, 2, 32'hDEAD_BEEF);
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, er, drd, dwr);
    check_all("lw_after_sw", 1'b0, 32'h10, lat, rd, er, drd, dwr, 32'hDEAD_BEEF, 1'b0, FL, 32'h0);
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      sg = 1'($urandom);
      a = $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0) a = a & ~((32'h1 << sz) - 1) & 32'h3F;
      wd = $urandom;
      model(we, sz, sg, a, wd, erd, eer, elat, ewd);
      run_req(we, sz, sg, a, wd, lat, rd, er, drd, dwr);
      check_all($sformatf("rnd%0d", i), we, a, lat, rd, er, drd, dwr, erd, eer, elat, ewd);
    end
    chk("strobe_overlap", nboth, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
